word_serial_tx: RTL
===================

Name: word_serial_tx

Overview:
- Transmitter that takes an 18-bit parallel word and sends it out on a single serial line.
- Frame: start bit, 18 data bits LSB first, optional even parity bit, stop bit.
- Sits downstream of the datapath's 18-bit holding registers and drives the link to the off-block receiver/deserializer.
- Uses a valid/ready handshake on the parallel side and a fixed clocks-per-bit timing on the serial side.

Parameters:
- DATA_W, 18, width of the parallel word and the number of serial data bits.
- CLKS_PER_BIT, 4, clk cycles each serial bit is held (legal range 2..255).
- PARITY_EN, 1, 1 = insert an even-parity bit after the data bits; 0 = no parity bit.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  parallel word on in_data is offered.
- in_data  input  DATA_W  word to transmit.
- in_ready  output  1  block accepts a word this cycle.
- tx  output  1  serial line; idle level is 1.
- busy  output  1  a frame is in progress.
- done  output  1  one-cycle pulse at the end of the stop bit.

Behaviour:
- Reset (rst=1 at a clk edge) gives: state=IDLE, tx=1, in_ready=1, busy=0, done=0; shift register, bit counter and timer cleared.
- Reset mid-frame aborts the frame. tx returns to 1 on the next edge, and there is no done pulse.
- Handshake:
  - Transfer occurs on an edge where in_valid=1 and in_ready=1.
  - in_ready=1 only in IDLE (registered).
  - in_data is captured into an internal DATA_W shift register at the transfer edge.
  - Parity is computed from the captured word (XOR reduction) at the same edge.
  - in_data may change freely afterwards.
- States: IDLE, START, DATA, PARITY, STOP.
  - IDLE: tx=1. On transfer, go to START; in_ready drops and busy rises at the same edge.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: tx=shift[0]; each bit is held CLKS_PER_BIT cycles, then the register shifts right by 1. After DATA_W bits, go to PARITY if PARITY_EN=1, else to STOP.
  - PARITY: tx=even parity bit (XOR of all data bits), held CLKS_PER_BIT cycles, then go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then go to IDLE. done=1 for the one cycle following the last stop cycle (registered at the IDLE entry edge); in_ready=1 in that same cycle.
- Bit timer:
  - Counts 0..CLKS_PER_BIT-1 and asserts a tick on the last count.
  - Resets to 0 on every state change.
  - Each state advances only on a tick.
- Bit counter: ceil(log2(DATA_W+1)) bits wide, counts data bits 0..DATA_W-1, cleared on entry to DATA.
- tx is a registered output (no combinational glitches). The first start-bit cycle appears the cycle after the transfer edge.
- Frame length: (1 + DATA_W + PARITY_EN + 1) x CLKS_PER_BIT cycles. With defaults: 21 x 4 = 84 cycles from the first start cycle to the last stop cycle.
- Back-to-back: a word offered with in_valid held high is accepted in the done cycle, so frames are separated by exactly one idle cycle of tx=1.
- in_valid asserted while busy is ignored (not an error). The upstream holds it until in_ready.
- in_data=all zeros and in_data=all ones need no special handling. Parity is 0 for 0x00000 and 0 for 0x3FFFF (18 ones = even count).

Decomposition:
- Shared package holds:
  - State encoding constants: IDLE=3'd0, START=3'd1, DATA=3'd2, PARITY=3'd3, STOP=3'd4.
  - DATA_W default of 18, shared with the holding registers and the receiver.
  - Idle line level constant (1).
- One sub-module: bit_timer. It takes parameter CLKS_PER_BIT and ports clk, rst, clear; it outputs tick.
- The FSM, shift register and bit counter stay in word_serial_tx.

Test Plan:
- Reset then idle:
  - Assert rst for 2 cycles, release, wait 10 cycles.
  - Required: tx=1, in_ready=1, busy=0, done=0 throughout.
- Single frame, defaults:
  - Send in_data=18'h2A5C3.
  - Required: tx=0 for 4 cycles, then bits 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1,0,1 (LSB first) at 4 cycles each.
  - Then parity=1 (9 ones → odd count → bit 1), then stop=1.
  - done pulses exactly 84 cycles after the first start cycle.
- Back-to-back:
  - Hold in_valid=1 with 18'h00000 then 18'h3FFFF.
  - Required: second word accepted in the done cycle, exactly one idle tx=1 cycle between the frames.
  - Parity bit=0 in both frames; in_ready high only in IDLE cycles.
- Busy ignore:
  - Pulse in_valid with 18'h12345 in the middle of a frame.
  - Required: no capture; the current frame is unchanged; no extra frame follows.
- Reset mid-frame:
  - Assert rst during data bit 7.
  - Required: tx=1 at the next edge, no done pulse, and a fresh frame with 18'h00001 transmits correctly afterwards.
- Parameter variant:
  - PARITY_EN=0, CLKS_PER_BIT=2, send 18'h3FFFF.
  - Required: frame = 20 bits x 2 = 40 cycles, no parity slot, stop follows data bit 17 directly.

Source files
------------

// File: rtl/word_serial_tx_pkg.sv
// rtl/word_serial_tx_pkg.sv - shared state encoding and line constants for word_serial_tx
package word_serial_tx_pkg;

    localparam int WST_DATA_W = 18;
    localparam logic IDLE_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

endpackage

// File: rtl/word_serial_tx_bit_timer.sv
// rtl/word_serial_tx_bit_timer.sv - per-bit cycle timer, ticks on the last cycle of each bit
module word_serial_tx_bit_timer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst || clear || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/word_serial_tx.sv
// rtl/word_serial_tx.sv - parallel-to-serial word transmitter with start, LSB-first data, even parity, stop
module word_serial_tx
    import word_serial_tx_pkg::*;
#(
    parameter int DATA_W       = WST_DATA_W,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              tx,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    state_t            state;
    logic [DATA_W-1:0] shift;
    logic [CNT_W-1:0]  bit_cnt;
    logic              parity;
    logic              tick;

    // Holding the timer cleared in IDLE makes every frame start from count 0.
    word_serial_tx_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk  (clk),
        .rst  (rst),
        .clear(state == IDLE),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            shift    <= '0;
            bit_cnt  <= '0;
            parity   <= 1'b0;
            tx       <= IDLE_LEVEL;
            in_ready <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        shift    <= in_data;
                        parity   <= ^in_data;
                        state    <= START;
                        tx       <= 1'b0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                START: begin
                    if (tick) begin
                        state   <= DATA;
                        bit_cnt <= '0;
                        tx      <= shift[0];
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (bit_cnt == LAST_BIT) begin
                            if (PARITY_EN != 0) begin
                                state <= PARITY;
                                tx    <= parity;
                            end else begin
                                state <= STOP;
                                tx    <= IDLE_LEVEL;
                            end
                        end else begin
                            // tx is registered, so it takes the bit that becomes shift[0].
                            shift   <= shift >> 1;
                            bit_cnt <= bit_cnt + CNT_W'(1);
                            tx      <= shift[1];
                        end
                    end
                end
                PARITY: begin
                    if (tick) begin
                        state <= STOP;
                        tx    <= IDLE_LEVEL;
                    end
                end
                STOP: begin
                    if (tick) begin
                        state    <= IDLE;
                        tx       <= IDLE_LEVEL;
                        in_ready <= 1'b1;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    tx       <= IDLE_LEVEL;
                    in_ready <= 1'b1;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule
